// File: rtl/aggregator_bank_arbiter_if.sv
// rtl/aggregator_bank_arbiter_if.sv - bank-input and sample-output bundle for aggregator_bank_arbiter
// Optional ovf_count signal is present only when OVF_COUNT_EN is defined.
interface aggregator_bank_arbiter_if #(
    parameter int NUM_BANKS     = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int CH_ID_WIDTH   = 4,
    parameter int BANK_ID_WIDTH = 2
) ();
    logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_data;
    logic [NUM_BANKS*CH_ID_WIDTH-1:0] bank_channel;
    logic [NUM_BANKS-1:0]             bank_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CH_ID_WIDTH-1:0]           out_channel;
    logic [BANK_ID_WIDTH-1:0]         out_bank;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_BANKS-1:0]             ovf_flags;
    logic                             ovf_clear;
`ifdef OVF_COUNT_EN
    logic [NUM_BANKS*8-1:0]           ovf_count;
`endif

    modport slave (
`ifdef OVF_COUNT_EN
        output ovf_count,
`endif
        input  bank_data, bank_channel, bank_valid, out_ready, ovf_clear,
        output out_data, out_channel, out_bank, out_valid, ovf_flags
    );

    modport master (
`ifdef OVF_COUNT_EN
        input  ovf_count,
`endif
        output bank_data, bank_channel, bank_valid, out_ready, ovf_clear,
        input  out_data, out_channel, out_bank, out_valid, ovf_flags
    );
endinterface

// File: rtl/aggregator_bank_arbiter.sv
// rtl/aggregator_bank_arbiter.sv - per-bank FIFOs drained round-robin into one registered sample stream
// Define OVF_COUNT_EN to add 8-bit saturating per-bank drop counters on ovf_count.
module aggregator_bank_arbiter #(
    parameter int NUM_BANKS     = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int CH_ID_WIDTH   = 4,
    parameter int BANK_ID_WIDTH = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    aggregator_bank_arbiter_if.slave bus
);
    localparam int IDX_W   = $clog2(NUM_BANKS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + CH_ID_WIDTH;

    logic [NUM_BANKS-1:0]              nonempty, push, drop, pop;
    logic [NUM_BANKS-1:0][ENTRY_W-1:0] heads;
    logic [ENTRY_W-1:0]                head_sel;
    logic [NUM_BANKS-1:0]              upto_last, req_hi, req_sel;
    logic [IDX_W-1:0]                  grant_idx, last_grant_q;
    logic                              grant_any, load_en;

    logic [DATA_WIDTH-1:0]             out_data_q;
    logic [CH_ID_WIDTH-1:0]            out_channel_q;
    logic [BANK_ID_WIDTH-1:0]          out_bank_q;
    logic                              out_valid_q;
    logic [NUM_BANKS-1:0]              ovf_flags_q, ovf_flags_d;

    assign load_en = !out_valid_q || bus.out_ready;

    // Requests above last_grant win; otherwise wrap to the lowest non-empty bank.
    always_comb begin
        upto_last = (NUM_BANKS'(2) << last_grant_q) - NUM_BANKS'(1);
        req_hi    = nonempty & ~upto_last;
        req_sel   = (|req_hi) ? req_hi : nonempty;
        grant_any = |nonempty;
        grant_idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (req_sel[i]) grant_idx = IDX_W'(i);
        end
    end

    assign head_sel = heads[grant_idx];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]   count_q, count_d;

        // Fullness uses the registered count, so a full FIFO drops even when popped this cycle.
        assign push[g]     = bus.bank_valid[g] && (count_q < CNT_W'(FIFO_DEPTH));
        assign drop[g]     = bus.bank_valid[g] && !push[g];
        assign pop[g]      = load_en && grant_any && (grant_idx == IDX_W'(g));
        assign nonempty[g] = (count_q != '0);
        assign heads[g]    = mem_q[rd_ptr_q];

        always_comb begin
            count_d = count_q;
            case ({push[g], pop[g]})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push[g]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop[g])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= {bus.bank_data[g*DATA_WIDTH +: DATA_WIDTH],
                                    bus.bank_channel[g*CH_ID_WIDTH +: CH_ID_WIDTH]};
            end
        end

`ifdef OVF_COUNT_EN
        logic [7:0] drop_cnt_q, drop_cnt_d;

        always_comb begin
            drop_cnt_d = bus.ovf_clear ? 8'd0 : drop_cnt_q;
            if (drop[g] && drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
        end

        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) drop_cnt_q <= 8'd0;
            else     drop_cnt_q <= drop_cnt_d;
        end

        assign bus.ovf_count[g*8 +: 8] = drop_cnt_q;
`endif
    end

    always_comb begin
        ovf_flags_d = (ovf_flags_q & ~{NUM_BANKS{bus.ovf_clear}}) | drop;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_bank_q    <= '0;
            out_valid_q   <= 1'b0;
            ovf_flags_q   <= '0;
            last_grant_q  <= IDX_W'(NUM_BANKS - 1);
        end else begin
            ovf_flags_q <= ovf_flags_d;
            if (load_en) begin
                if (grant_any) begin
                    out_data_q    <= head_sel[ENTRY_W-1 -: DATA_WIDTH];
                    out_channel_q <= head_sel[CH_ID_WIDTH-1:0];
                    out_bank_q    <= BANK_ID_WIDTH'(grant_idx);
                    out_valid_q   <= 1'b1;
                    last_grant_q  <= grant_idx;
                end else begin
                    out_valid_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;
    assign bus.out_bank    = out_bank_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.ovf_flags   = ovf_flags_q;
endmodule

// File: tb/tb_aggregator_bank_arbiter.sv
// tb/tb_aggregator_bank_arbiter.sv - scoreboard bench for aggregator_bank_arbiter
module tb_aggregator_bank_arbiter;
    typedef struct packed {
        logic [1:0]  bank;
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic sys_clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    aggregator_bank_arbiter_if #(
        .NUM_BANKS(4), .DATA_WIDTH(16), .CH_ID_WIDTH(4), .BANK_ID_WIDTH(2)
    ) bus ();

    aggregator_bank_arbiter #(
        .NUM_BANKS(4), .DATA_WIDTH(16), .CH_ID_WIDTH(4), .BANK_ID_WIDTH(2), .FIFO_DEPTH(4)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        bus.bank_valid = '0;
        bus.ovf_clear  = 1'b0;
    endtask

    task automatic drive(input int b, input logic [15:0] d, input logic [3:0] c);
        bus.bank_valid[b]          = 1'b1;
        bus.bank_data[b*16 +: 16]  = d;
        bus.bank_channel[b*4 +: 4] = c;
    endtask

    task automatic expect_s(input int b, input logic [15:0] d, input logic [3:0] c);
        exp_t e;
        e.bank = 2'(b);
        e.ch   = c;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
    always @(negedge sys_clk) begin : monitor
        exp_t act;
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            act = {bus.out_bank, bus.out_channel, bus.out_data};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got %h expected none", act);
            end else begin
                e = sb_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_sample got %h expected %h", act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.bank_data    = '0;
        bus.bank_channel = '0;
        idle();
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data), 32'd0);
        chk("rst_flags", 32'(bus.ovf_flags), 32'd0);
        rst = 1'b0;
        step();

        // Single sample, latency one edge after capture
        drive(2, 16'h1234, 4'd5);
        expect_s(2, 16'h1234, 4'd5);
        step();
        idle();
        chk("lat_edge_t", 32'(bus.out_valid), 32'd0);
        step();
        chk("lat_edge_t1", 32'(bus.out_valid), 32'd1);
        step();
        chk("single_done", 32'(bus.out_valid), 32'd0);
        wait_drain("single_drain", 5);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // All banks at once from reset pointer: 0,1,2,3
        for (int i = 0; i < 4; i++) begin
            drive(i, 16'hA0 + 16'(i), 4'(i));
            expect_s(i, 16'hA0 + 16'(i), 4'(i));
        end
        step();
        idle();
        wait_drain("rr_drain", 20);
        step();

        // last_grant=3: bank 1 before bank 3
        drive(3, 16'hB3, 4'd3);
        drive(1, 16'hB1, 4'd1);
        expect_s(1, 16'hB1, 4'd1);
        expect_s(3, 16'hB3, 4'd3);
        step();
        idle();
        wait_drain("rr13_drain", 20);
        step();
        chk("rr13_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure and overflow on bank 0
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(0, 16'(k), 4'd0);
            if (k <= 5) expect_s(0, 16'(k), 4'd0);
            step();
        end
        idle();
        chk("bp_flags", 32'(bus.ovf_flags), 32'd1);
        chk("bp_hold_a", 32'(bus.out_data), 32'd1);
        step();
        step();
        chk("bp_hold_b", 32'(bus.out_data), 32'd1);
        chk("bp_hold_v", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        wait_drain("bp_drain", 20);
        step();
        step();
        chk("bp_no6", 32'(bus.out_valid), 32'd0);

        // Full FIFO with simultaneous pop: push still dropped
        bus.ovf_clear = 1'b1;
        step();
        idle();
        chk("fp_cleared", 32'(bus.ovf_flags), 32'd0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 16'h11 + 16'(k), 4'd1);
            expect_s(0, 16'h11 + 16'(k), 4'd1);
            step();
        end
        chk("fp_noflag", 32'(bus.ovf_flags), 32'd0);
        bus.out_ready = 1'b1;
        drive(0, 16'h16, 4'd1);
        step();
        idle();
        chk("fp_flag", 32'(bus.ovf_flags), 32'd1);
        chk("fp_popped", 32'(bus.out_data), 32'h12);
        wait_drain("fp_drain", 20);
        step();

        // Clear versus drop on bank 1
        bus.ovf_clear = 1'b1;
        step();
        idle();
        chk("cd_clr_idle", 32'(bus.ovf_flags), 32'd0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 16'h21 + 16'(k), 4'd2);
            expect_s(1, 16'h21 + 16'(k), 4'd2);
            step();
        end
        drive(1, 16'h26, 4'd2);
        step();
        chk("cd_drop", 32'(bus.ovf_flags), 32'd2);
`ifdef OVF_COUNT_EN
        chk("cd_cnt_one", 32'(bus.ovf_count[15:8]), 32'd1);
`endif
        drive(1, 16'h27, 4'd2);
        bus.ovf_clear = 1'b1;
        step();
        idle();
        chk("cd_set_wins", 32'(bus.ovf_flags), 32'd2);
`ifdef OVF_COUNT_EN
        chk("cd_cnt_clr_drop", 32'(bus.ovf_count[15:8]), 32'd1);
`endif
        bus.ovf_clear = 1'b1;
        step();
        idle();
        chk("cd_clr_after", 32'(bus.ovf_flags), 32'd0);
`ifdef OVF_COUNT_EN
        chk("cd_cnt_zero", 32'(bus.ovf_count[15:8]), 32'd0);
`endif
        bus.out_ready = 1'b1;
        wait_drain("cd_drain", 20);
        step();

        // Reset in mid-operation
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 16'h31 + 16'(k), 4'd3);
            step();
        end
        idle();
        chk("mr_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("mr_pre_flags", 32'(bus.ovf_flags), 32'd1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("mr_async_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_async_flags", 32'(bus.ovf_flags), 32'd0);
        chk("mr_async_data", 32'(bus.out_data), 32'd0);
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("mr_no_stale", 32'(bus.out_valid), 32'd0);
        drive(3, 16'hC3, 4'd3);
        drive(1, 16'hC1, 4'd1);
        expect_s(1, 16'hC1, 4'd1);
        expect_s(3, 16'hC3, 4'd3);
        step();
        idle();
        wait_drain("mr_drain", 20);
        step();
        step();
        chk("mr_idle", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
